flags_cond_unit: RTL

// - Consumer end of the ALU flag interface (CPSR_flags/write_flags).
// - Holds the architectural NZCV register for the LEGv8 pipeline and evaluates
//   B.cond conditions against it.
// - Sits beside EX: the ALU drives flag writes, the decoder drives the condition

---
 rtl/flags_cond_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/flags_cond_unit.sv
// rtl/flags_cond_unit.sv - NZCV flag register with registered B.cond evaluation
//
// Purpose:
//   Holds the architectural {Z,N,C,V} flags written by the ALU and evaluates
//   B.cond condition codes against them. The taken/valid result is registered
//   and presented to PC-select one cycle after the condition is presented.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   CPSR_flags_i    {Z,N,C,V} from the ALU ([3]=Z [2]=N [1]=C [0]=V)
//   write_flags_i   flag-write request, qualifies CPSR_flags_i
//   cond_valid_i    a B.cond is presented this cycle
//   cond_i          condition code
//   stall_i         freeze every piece of state
//   flush_i         squash this cycle's write and evaluation
//   flags_o         stored {Z,N,C,V}
//   br_valid_o      registered evaluation-valid pulse
//   br_taken_o      registered condition-true
//   taken_cnt_o     saturating count of taken evaluations
module flags_cond_unit #(
  parameter int         FWD_EN      = 1,
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       CPSR_flags_i,
  input  logic             write_flags_i,
  input  logic             cond_valid_i,
  input  logic [3:0]       cond_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [3:0]       flags_o,
  output logic             br_valid_o,
  output logic             br_taken_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]       flags_q, flags_d;
  logic             br_valid_q, br_valid_d;
  logic             br_taken_q, br_taken_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic [3:0]       eval_flags;
  logic             cond_true;

  // C=1 means "no borrow", so HS/LO/HI/LS follow the unsigned-compare sense.
  function automatic logic eval_cond(input logic [3:0] cc, input logic [3:0] f);
    logic z, n, c, v;
    z = f[3];
    n = f[2];
    c = f[1];
    v = f[0];
    case (cc)
      4'b0000: eval_cond = z;
      4'b0001: eval_cond = !z;
      4'b0010: eval_cond = c;
      4'b0011: eval_cond = !c;
      4'b0100: eval_cond = n;
      4'b0101: eval_cond = !n;
      4'b0110: eval_cond = v;
      4'b0111: eval_cond = !v;
      4'b1000: eval_cond = c & !z;
      4'b1001: eval_cond = !c | z;
      4'b1010: eval_cond = (n == v);
      4'b1011: eval_cond = (n != v);
      4'b1100: eval_cond = !z & (n == v);
      4'b1101: eval_cond = z | (n != v);
      default: eval_cond = 1'b1;
    endcase
  endfunction

  always_comb begin
    // Bypass lets a B.cond directly behind the flag-setting op resolve
    // against the flags being written this cycle.
    if ((FWD_EN != 0) && write_flags_i) eval_flags = CPSR_flags_i;
    else                                eval_flags = flags_q;
    cond_true = eval_cond(cond_i, eval_flags);
  end

  always_comb begin
    flags_d     = flags_q;
    br_valid_d  = br_valid_q;
    br_taken_d  = br_taken_q;
    taken_cnt_d = taken_cnt_q;
    if (!stall_i) begin
      if (flush_i) begin
        br_valid_d = 1'b0;
        br_taken_d = 1'b0;
      end else begin
        if (write_flags_i) flags_d = CPSR_flags_i;
        br_valid_d = cond_valid_i;
        br_taken_d = cond_valid_i & cond_true;
        if (cond_valid_i && cond_true && (taken_cnt_q != CNT_MAX))
          taken_cnt_d = taken_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q     <= RESET_FLAGS;
      br_valid_q  <= 1'b0;
      br_taken_q  <= 1'b0;
      taken_cnt_q <= '0;
    end else begin
      flags_q     <= flags_d;
      br_valid_q  <= br_valid_d;
      br_taken_q  <= br_taken_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign flags_o     = flags_q;
  assign br_valid_o  = br_valid_q;
  assign br_taken_o  = br_taken_q;
  assign taken_cnt_o = taken_cnt_q;

endmodule
